// File: rtl/exe_stage_if.sv
// EXE-stage bus: ID2EXE fields, MEM/WB forwarding taps and EXE outputs.
// master drives the stage inputs, slave is the execute stage itself.
interface exe_stage_if;
  logic        freeze;
  logic        status_en;
  logic        mem_read;
  logic        mem_write;
  logic        wb_en;
  logic        branch;
  logic        I;
  logic [31:0] pc;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [3:0]  aluCommand;
  logic [3:0]  dest;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic [3:0]  status_in;
  logic [23:0] b_signed_imm;
  logic [11:0] shifter_operand;
  logic        mem_wb_en;
  logic [3:0]  mem_dest;
  logic [31:0] mem_alu_res;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [31:0] alu_res;
  logic [31:0] val_rm;
  logic [31:0] branch_addr;
  logic        branch_taken;
  logic [3:0]  status_reg;
  logic        wb_en_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [3:0]  dest_out;

  modport master (
    output freeze, status_en, mem_read, mem_write, wb_en, branch, I,
    output pc, reg1, reg2, aluCommand, dest, src1, src2, status_in,
    output b_signed_imm, shifter_operand,
    output mem_wb_en, mem_dest, mem_alu_res, wb_wb_en, wb_dest, wb_value,
    input  alu_res, val_rm, branch_addr, branch_taken, status_reg,
    input  wb_en_out, mem_read_out, mem_write_out, dest_out
  );

  modport slave (
    input  freeze, status_en, mem_read, mem_write, wb_en, branch, I,
    input  pc, reg1, reg2, aluCommand, dest, src1, src2, status_in,
    input  b_signed_imm, shifter_operand,
    input  mem_wb_en, mem_dest, mem_alu_res, wb_wb_en, wb_dest, wb_value,
    output alu_res, val_rm, branch_addr, branch_taken, status_reg,
    output wb_en_out, mem_read_out, mem_write_out, dest_out
  );
endinterface

// File: rtl/exe_stage.sv
// ARM execute stage: operand-2 shifter, ALU, branch target, NZCV register.
// Optional FORWARDING_EN macro enables MEM/WB operand forwarding.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);
  logic [31:0] a;
  logic [31:0] rm;
  logic [31:0] b;
  logic [31:0] res;
  logic [32:0] sum;
  logic        n, z, c, v;
  logic [3:0]  status_q;
  logic [63:0] rot;
  logic [4:0]  shamt;

`ifdef FORWARDING_EN
  always_comb begin
    a = bus.reg1;
    if (bus.mem_wb_en && bus.mem_dest == bus.src1)
      a = bus.mem_alu_res;
    else if (bus.wb_wb_en && bus.wb_dest == bus.src1)
      a = bus.wb_value;
    rm = bus.reg2;
    if (bus.mem_wb_en && bus.mem_dest == bus.src2)
      rm = bus.mem_alu_res;
    else if (bus.wb_wb_en && bus.wb_dest == bus.src2)
      rm = bus.wb_value;
  end
`else
  assign a  = bus.reg1;
  assign rm = bus.reg2;
`endif

  always_comb begin
    b     = rm;
    rot   = '0;
    shamt = bus.shifter_operand[11:7];
    if (bus.mem_read || bus.mem_write) begin
      b = {20'd0, bus.shifter_operand};
    end else if (bus.I) begin
      rot = {2{24'd0, bus.shifter_operand[7:0]}}
            >> {bus.shifter_operand[11:8], 1'b0};
      b   = rot[31:0];
    end else begin
      unique case (bus.shifter_operand[6:5])
        2'b00: b = rm << shamt;
        2'b01: b = rm >> shamt;
        2'b10: b = $unsigned($signed(rm) >>> shamt);
        default: begin
          rot = {rm, rm} >> shamt;
          b   = rot[31:0];
        end
      endcase
    end
  end

  // SUB/SBC add ~B so the carry out is already NOT borrow
  always_comb begin
    sum = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (bus.aluCommand)
      4'b0001: res = b;
      4'b1001: res = ~b;
      4'b0010: sum = {1'b0, a} + {1'b0, b};
      4'b0011: sum = {1'b0, a} + {1'b0, b} + {32'd0, bus.status_in[1]};
      4'b0100: sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
      4'b0101: sum = {1'b0, a} + {1'b0, ~b} + {32'd0, bus.status_in[1]};
      4'b0110: res = a & b;
      4'b0111: res = a | b;
      4'b1000: res = a ^ b;
      default: res = '0;
    endcase
    case (bus.aluCommand)
      4'b0010, 4'b0011: begin
        res = sum[31:0];
        c   = sum[32];
        v   = (a[31] == b[31]) && (res[31] != a[31]);
      end
      4'b0100, 4'b0101: begin
        res = sum[31:0];
        c   = sum[32];
        v   = (a[31] != b[31]) && (res[31] != a[31]);
      end
      default: ;
    endcase
  end

  assign n = res[31];
  assign z = (res == 32'd0);

  always_ff @(posedge clk) begin
    if (rst)
      status_q <= 4'b0000;
    else if (bus.status_en && !bus.freeze)
      status_q <= {n, z, c, v};
  end

  assign bus.status_reg    = status_q;
  assign bus.alu_res       = res;
  assign bus.val_rm        = rm;
  assign bus.branch_addr   = bus.pc
    + {{6{bus.b_signed_imm[23]}}, bus.b_signed_imm, 2'b00};
  assign bus.branch_taken  = bus.branch;
  assign bus.wb_en_out     = bus.wb_en;
  assign bus.mem_read_out  = bus.mem_read;
  assign bus.mem_write_out = bus.mem_write;
  assign bus.dest_out      = bus.dest;
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus random
// stimulus against an arithmetic reference model.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_stage_if bus ();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int passed = 0;
  int total  = 0;
  logic [3:0] model_st = 4'b0000;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  task automatic clear_inputs();
    bus.freeze = 0; bus.status_en = 0; bus.mem_read = 0;
    bus.mem_write = 0; bus.wb_en = 0; bus.branch = 0; bus.I = 0;
    bus.pc = 0; bus.reg1 = 0; bus.reg2 = 0; bus.aluCommand = 0;
    bus.dest = 0; bus.src1 = 0; bus.src2 = 0; bus.status_in = 0;
    bus.b_signed_imm = 0; bus.shifter_operand = 0;
    bus.mem_wb_en = 0; bus.mem_dest = 0; bus.mem_alu_res = 0;
    bus.wb_wb_en = 0; bus.wb_dest = 0; bus.wb_value = 0;
  endtask

  function automatic logic [31:0] model_fwd(input logic [3:0] src,
                                            input logic [31:0] regv);
`ifdef FORWARDING_EN
    if (bus.mem_wb_en && bus.mem_dest == src) return bus.mem_alu_res;
    if (bus.wb_wb_en && bus.wb_dest == src) return bus.wb_value;
`endif
    return regv;
  endfunction

  // Bit-serial shifter: one single-bit step per shift position
  function automatic logic [31:0] model_val2(input logic memop,
      input logic imm, input logic [11:0] so, input logic [31:0] rmv);
    logic [31:0] x;
    int cnt;
    if (memop) return {20'd0, so};
    if (imm) begin
      x = {24'd0, so[7:0]};
      cnt = 2 * int'(so[11:8]);
      for (int k = 0; k < cnt; k++) x = {x[0], x[31:1]};
      return x;
    end
    x = rmv;
    cnt = int'(so[11:7]);
    for (int k = 0; k < cnt; k++) begin
      case (so[6:5])
        2'b00: x = {x[30:0], 1'b0};
        2'b01: x = {1'b0, x[31:1]};
        2'b10: x = {x[31], x[31:1]};
        default: x = {x[0], x[31:1]};
      endcase
    end
    return x;
  endfunction

  // Returns {N,Z,C,V, result} using wide integer arithmetic
  function automatic logic [35:0] model_alu(input logic [3:0] cmd,
      input logic [31:0] a, input logic [31:0] b, input logic cin);
    longint ua, ub, sa, sb, full, sv, k;
    logic [31:0] r;
    logic cf, vf;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    k = cin ? 64'sd1 : 64'sd0;
    cf = 0; vf = 0; r = 0; full = 0; sv = 0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd2, 4'd3: begin
        if (cmd == 4'd2) k = 0;
        full = ua + ub + k;
        sv = sa + sb + k;
        cf = full > 64'sd4294967295;
        vf = (sv > MAXS) || (sv < MINS);
        r = full[31:0];
      end
      4'd4, 4'd5: begin
        k = (cmd == 4'd4) ? 64'sd0 : (cin ? 64'sd0 : 64'sd1);
        full = ua - ub - k;
        sv = sa - sb - k;
        cf = ua >= (ub + k);
        vf = (sv > MAXS) || (sv < MINS);
        r = full[31:0];
      end
      default: r = 0;
    endcase
    return {r[31], (r == 0), cf, vf, r};
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    bus.status_en = 1; bus.aluCommand = 4'b0010;
    bus.reg1 = 32'hFFFF_FFFF; bus.I = 1; bus.shifter_operand = 12'h001;
    @(posedge clk); #1;
    total++;
    if (bus.status_reg !== 4'b0000)
      $display("FAIL reset_status got=%b exp=0000", bus.status_reg);
    else passed++;
    total++;
    if (bus.alu_res !== 32'd0)
      $display("FAIL reset_alu got=%h exp=00000000", bus.alu_res);
    else passed++;
    rst = 0;
    @(posedge clk); #1;
    model_st = 4'b0110;
    total++;
    if (bus.status_reg !== 4'b0110)
      $display("FAIL post_reset_status got=%b exp=0110", bus.status_reg);
    else passed++;
  endtask

  task automatic test_add_overflow();
    @(negedge clk);
    clear_inputs();
    bus.status_en = 1; bus.aluCommand = 4'b0010;
    bus.reg1 = 32'h7FFF_FFFF; bus.I = 1; bus.shifter_operand = 12'h001;
    #1;
    total++;
    if (bus.alu_res !== 32'h8000_0000)
      $display("FAIL ovf_alu got=%h exp=80000000", bus.alu_res);
    else passed++;
    @(posedge clk); #1;
    model_st = 4'b1001;
    total++;
    if (bus.status_reg !== 4'b1001)
      $display("FAIL ovf_status got=%b exp=1001", bus.status_reg);
    else passed++;
  endtask

  task automatic test_shifter();
    @(negedge clk);
    clear_inputs();
    bus.aluCommand = 4'b0001; bus.I = 1; bus.shifter_operand = 12'h4FF;
    #1;
    total++;
    if (bus.alu_res !== 32'hFF00_0000)
      $display("FAIL rot_imm got=%h exp=ff000000", bus.alu_res);
    else passed++;
    bus.I = 0; bus.reg2 = 32'h8000_0000; bus.shifter_operand = 12'h240;
    #1;
    total++;
    if (bus.alu_res !== 32'hF800_0000)
      $display("FAIL asr got=%h exp=f8000000", bus.alu_res);
    else passed++;
    bus.mem_write = 1; bus.shifter_operand = 12'hABC;
    #1;
    total++;
    if (bus.alu_res !== 32'h0000_0ABC)
      $display("FAIL mem_imm got=%h exp=00000abc", bus.alu_res);
    else passed++;
  endtask

  task automatic test_forwarding();
    logic [31:0] e1, e2;
`ifdef FORWARDING_EN
    e1 = 32'd11; e2 = 32'd21;
`else
    e1 = 32'd6; e2 = 32'd6;
`endif
    @(negedge clk);
    clear_inputs();
    bus.aluCommand = 4'b0010; bus.I = 1; bus.shifter_operand = 12'h001;
    bus.src1 = 3; bus.reg1 = 5;
    bus.mem_dest = 3; bus.mem_wb_en = 1; bus.mem_alu_res = 10;
    bus.wb_dest = 3; bus.wb_wb_en = 1; bus.wb_value = 20;
    #1;
    total++;
    if (bus.alu_res !== e1)
      $display("FAIL fwd_mem got=%0d exp=%0d", bus.alu_res, e1);
    else passed++;
    bus.mem_wb_en = 0;
    #1;
    total++;
    if (bus.alu_res !== e2)
      $display("FAIL fwd_wb got=%0d exp=%0d", bus.alu_res, e2);
    else passed++;
  endtask

  task automatic test_freeze();
    @(negedge clk);
    clear_inputs();
    bus.aluCommand = 4'b0100; bus.reg1 = 5; bus.I = 1;
    bus.shifter_operand = 12'h005; bus.status_en = 1; bus.freeze = 1;
    @(posedge clk); #1;
    total++;
    if (bus.status_reg !== 4'b1001)
      $display("FAIL freeze_hold got=%b exp=1001", bus.status_reg);
    else passed++;
    bus.freeze = 0;
    @(posedge clk); #1;
    model_st = 4'b0110;
    total++;
    if (bus.status_reg !== 4'b0110)
      $display("FAIL freeze_release got=%b exp=0110", bus.status_reg);
    else passed++;
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    bus.pc = 32'h100; bus.branch = 1; bus.b_signed_imm = 24'hFFFFFE;
    #1;
    total++;
    if (bus.branch_taken !== 1'b1)
      $display("FAIL br_taken got=%b exp=1", bus.branch_taken);
    else passed++;
    total++;
    if (bus.branch_addr !== 32'h0F8)
      $display("FAIL br_addr got=%h exp=000000f8", bus.branch_addr);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] a, rmv, b, e_addr;
    logic [35:0] r;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      bus.freeze = ($urandom_range(0, 5) == 0);
      bus.status_en = $urandom_range(0, 1);
      bus.mem_read = ($urandom_range(0, 7) == 0);
      bus.mem_write = ($urandom_range(0, 7) == 0);
      bus.wb_en = $urandom_range(0, 1);
      bus.branch = $urandom_range(0, 1);
      bus.I = $urandom_range(0, 1);
      bus.pc = $urandom;
      bus.reg1 = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      bus.reg2 = $urandom;
      bus.aluCommand = 4'($urandom_range(0, 15));
      bus.dest = 4'($urandom);
      bus.src1 = 4'($urandom_range(0, 3));
      bus.src2 = 4'($urandom_range(0, 3));
      bus.status_in = 4'($urandom);
      bus.b_signed_imm = 24'($urandom);
      bus.shifter_operand = 12'($urandom);
      bus.mem_wb_en = $urandom_range(0, 1);
      bus.mem_dest = 4'($urandom_range(0, 3));
      bus.mem_alu_res = $urandom;
      bus.wb_wb_en = $urandom_range(0, 1);
      bus.wb_dest = 4'($urandom_range(0, 3));
      bus.wb_value = $urandom;
      #1;
      a = model_fwd(bus.src1, bus.reg1);
      rmv = model_fwd(bus.src2, bus.reg2);
      b = model_val2(bus.mem_read | bus.mem_write, bus.I,
                     bus.shifter_operand, rmv);
      r = model_alu(bus.aluCommand, a, b, bus.status_in[1]);
      e_addr = bus.pc + 32'($signed(bus.b_signed_imm)) * 4;
      total++;
      if (bus.alu_res !== r[31:0])
        $display("FAIL rnd_alu it=%0d cmd=%h got=%h exp=%h",
                 it, bus.aluCommand, bus.alu_res, r[31:0]);
      else passed++;
      total++;
      if (bus.val_rm !== rmv)
        $display("FAIL rnd_valrm it=%0d got=%h exp=%h", it, bus.val_rm, rmv);
      else passed++;
      total++;
      if (bus.branch_addr !== e_addr || bus.branch_taken !== bus.branch)
        $display("FAIL rnd_branch it=%0d got=%h/%b exp=%h/%b", it,
                 bus.branch_addr, bus.branch_taken, e_addr, bus.branch);
      else passed++;
      total++;
      if ({bus.wb_en_out, bus.mem_read_out, bus.mem_write_out, bus.dest_out}
          !== {bus.wb_en, bus.mem_read, bus.mem_write, bus.dest})
        $display("FAIL rnd_pass it=%0d got=%b exp=%b", it,
                 {bus.wb_en_out, bus.mem_read_out, bus.mem_write_out,
                  bus.dest_out},
                 {bus.wb_en, bus.mem_read, bus.mem_write, bus.dest});
      else passed++;
      if (bus.status_en && !bus.freeze) model_st = r[35:32];
      @(posedge clk); #1;
      total++;
      if (bus.status_reg !== model_st)
        $display("FAIL rnd_status it=%0d got=%b exp=%b",
                 it, bus.status_reg, model_st);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1;
    bus.status_en = 1; bus.freeze = 0;
    @(posedge clk); #1;
    model_st = 4'b0000;
    total++;
    if (bus.status_reg !== 4'b0000)
      $display("FAIL mid_reset got=%b exp=0000", bus.status_reg);
    else passed++;
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_shifter();
    test_forwarding();
    test_freeze();
    test_branch();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
